piso_serializer: RTL

Parallel-in serial-out serializer that sits directly upstream of the 4-bit SISO shift register and drives its serial `in` input. It accepts parallel words over a valid/ready handshake, holds one pending word in a skid register, and emits bits one per clock with framing strobes. Back-to-back words stream with no idle cycle between frames.

---
 rtl/ser_pkg.sv | 9 +
 rtl/piso_serializer_if.sv | 12 +
 rtl/ser_hold_buf.sv | 19 +
 rtl/piso_serializer.sv | 47 ++++
 4 files changed

// File: rtl/ser_pkg.sv
// ser_pkg: shared constants and helpers for the serializer slice
package ser_pkg;
  localparam int WIDTH_D = 4;
  localparam bit MSB_FIRST_C = 1'b1;
  localparam bit LSB_FIRST_C = 1'b0;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake plus framed serial output of the serializer
interface piso_serializer_if import ser_pkg::*; #(parameter int WIDTH = WIDTH_D);
  logic [WIDTH-1:0] din;
  logic load_valid;
  logic load_ready;
  logic sout;
  logic sout_valid;
  logic frame_start;
  logic frame_last;
  modport master (output din, load_valid, input load_ready, sout, sout_valid, frame_start, frame_last);
  modport slave (input din, load_valid, output load_ready, sout, sout_valid, frame_start, frame_last);
endinterface

// File: rtl/ser_hold_buf.sv
// ser_hold_buf: one-entry skid register; a read and write in the same cycle keeps it full
module ser_hold_buf import ser_pkg::*; #(parameter int WIDTH = WIDTH_D) (
  input  logic clk,
  input  logic reset,
  input  logic wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic full
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_data <= '0;
      full <= 1'b0;
    end else begin
      if (wr_en) rd_data <= wr_data;
      full <= wr_en | (full & ~rd_en);
    end
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with skid hold and frame strobes
module piso_serializer import ser_pkg::*; #(
  parameter int WIDTH = WIDTH_D,
  parameter bit MSB_FIRST = LSB_FIRST_C
) (
  input logic clk,
  input logic reset,
  piso_serializer_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  logic [WIDTH-1:0] shreg, hold;
  logic [CW-1:0] cnt;
  logic busy, hold_full, lp, acc, last;
  assign last = cnt == CW'(WIDTH-1);
  assign lp = !busy || last;
  assign acc = bus.load_valid && !hold_full;
  // mid-frame accepts park in hold; at a load point with hold empty the word bypasses it
  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk(clk),
    .reset(reset),
    .wr_en(acc && !lp),
    .wr_data(bus.din),
    .rd_en(lp && hold_full),
    .rd_data(hold),
    .full(hold_full)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      shreg <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (lp) begin
      if (hold_full || acc) begin
        shreg <= hold_full ? hold : bus.din;
        cnt <= '0;
        busy <= 1'b1;
      end else busy <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      shreg <= MSB_FIRST ? shreg << 1 : shreg >> 1;
    end
  assign bus.load_ready = !hold_full;
  assign bus.sout = busy && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign bus.sout_valid = busy;
  assign bus.frame_start = busy && cnt == '0;
  assign bus.frame_last = busy && last;
endmodule
